// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared opcode, sequencer state and decode helpers for the tinyalu datapath
package tinyalu_pkg;

  typedef enum logic [3:0] {
    no_op    = 4'h0,
    op_add   = 4'h1,
    op_and   = 4'h2,
    op_xor   = 4'h3,
    op_mul   = 4'h4,
    op_load  = 4'h8,
    op_store = 4'h9
  } alu_opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    MEM_WAIT,
    ALU_WAIT,
    RETIRE
  } seq_state_t;

  function automatic logic is_mem_op(input alu_opcode_t o);
    return (o == op_load) || (o == op_store);
  endfunction

  function automatic logic is_alu_op(input alu_opcode_t o);
    return (o == op_add) || (o == op_and) || (o == op_xor) || (o == op_mul);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous instruction queue with registered full/empty flags
module instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic [WIDTH-1:0] out_tdata,
  input  logic             out_tready,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push, pop;

  assign push      = in_tvalid & ~full_q;
  assign pop       = out_tready & ~empty_q;
  assign out_tdata = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;

  // Pointers are PTR_W wide, so they wrap at DEPTH on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_tdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    full_d  = (count_d == (PTR_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - queued in-order instruction sequencer driving memory unit and ALU
// Optional INSTR_SEQ_PERF_EN adds retired_cnt / stall_cnt performance counters.
module instr_sequencer
  import tinyalu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 14,
  parameter int NUM_REGS   = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int REG_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int INSTR_W   = 4 + ADDR_W + REG_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                mem_done,
  input  logic [DATA_W-1:0]   data,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                start,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  output alu_opcode_t         op,
  output logic [ADDR_W-1:0]   addr,
  output logic [2*DATA_W-1:0] result,
  output logic                load,
  output logic                store,
  output logic                done
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [31:0]         retired_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  function automatic logic [REG_W-1:0] wrap_idx(input logic [REG_W-1:0] i);
    return REG_W'({1'b0, i} % (REG_W+1)'(NUM_REGS));
  endfunction

  seq_state_t          state_q, state_d;
  logic [INSTR_W-1:0]  cur_q, cur_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [2*DATA_W-1:0] result_q, result_d;
  alu_opcode_t         op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                start_q, start_d, load_q, load_d, store_q, store_d, done_q, done_d;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [INSTR_W-1:0]  fifo_head;
  alu_opcode_t         cur_op;
  logic [ADDR_W-1:0]   cur_iaddr;
  logic [REG_W-1:0]    cur_rsel, src_a, src_b;

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_tdata   (instr),
    .in_tvalid  (instr_valid),
    .out_tdata  (fifo_head),
    .out_tready (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign instr_ready = ~fifo_full;

  assign cur_op    = alu_opcode_t'(cur_q[INSTR_W-1 -: 4]);
  assign cur_iaddr = cur_q[REG_W +: ADDR_W];
  assign cur_rsel  = wrap_idx(cur_q[REG_W-1:0]);
  assign src_a     = wrap_idx(cur_iaddr[REG_W-1:0]);
  assign src_b     = wrap_idx(cur_iaddr[2*REG_W-1:REG_W]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      result_q <= '0;
      op_q     <= no_op;
      addr_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      start_q  <= 1'b0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      result_q <= result_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      start_q  <= start_d;
      load_q   <= load_d;
      store_q  <= store_d;
      done_q   <= done_d;
      regs_q   <= regs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = ISSUE;
          fifo_pop = 1'b1;
        end
      end
      ISSUE: begin
        if (is_mem_op(cur_op))      state_d = MEM_WAIT;
        else if (is_alu_op(cur_op)) state_d = ALU_WAIT;
        else                        state_d = RETIRE;
      end
      MEM_WAIT: if (mem_done) state_d = RETIRE;
      ALU_WAIT: if (alu_done) state_d = RETIRE;
      RETIRE:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Every output is the registered image of its _d value, so each request
  // rises one edge after ISSUE and falls on the edge that sees its done input.
  always_comb begin
    cur_d    = cur_q;
    regs_d   = regs_q;
    result_d = result_q;
    op_d     = op_q;
    addr_d   = addr_q;
    a_d      = a_q;
    b_d      = b_q;
    start_d  = 1'b0;
    load_d   = 1'b0;
    store_d  = 1'b0;
    done_d   = (state_d == RETIRE);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) cur_d = fifo_head;
      end
      ISSUE: begin
        op_d    = cur_op;
        addr_d  = cur_iaddr;
        a_d     = regs_q[src_a];
        b_d     = regs_q[src_b];
        load_d  = (cur_op == op_load);
        store_d = (cur_op == op_store);
        start_d = is_alu_op(cur_op);
      end
      MEM_WAIT: begin
        load_d  = load_q & ~mem_done;
        store_d = store_q & ~mem_done;
        if (mem_done && load_q) regs_d[cur_rsel] = data;
      end
      ALU_WAIT: begin
        start_d = ~alu_done;
        if (alu_done) result_d = alu_result;
      end
      default: ;
    endcase
  end

  assign start  = start_q;
  assign load   = load_q;
  assign store  = store_q;
  assign done   = done_q;
  assign op     = op_q;
  assign addr   = addr_q;
  assign A      = a_q;
  assign B      = b_q;
  assign result = result_q;

`ifdef INSTR_SEQ_PERF_EN
  logic [31:0] retired_cnt_q, retired_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q + 32'(state_q == RETIRE);
    stall_cnt_d   = stall_cnt_q + 32'(instr_valid & ~instr_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule
